// File: rtl/i2c_line_conditioner.sv
// rtl/i2c_line_conditioner.sv - I2C line readback synchroniser, glitch filter and bridge tick generator
// Optional stuck-low release compiled in with I2C_LINE_CONDITIONER_STUCK_EN.
module i2c_line_conditioner #(
  parameter int CLK_HZ      = 25000000,
  parameter int TICK_HZ     = 3000000,
  parameter int SYNC_STAGES = 2,
  parameter int FILTER_LEN  = 3,
  parameter int STUCK_TICKS = 75000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] pad_i,
  output logic       clk_en,
  output logic [1:0] o,
  output logic [1:0] stuck
);

  localparam int DIV_RAW = CLK_HZ / TICK_HZ;
  localparam int DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;
  localparam int PW      = $clog2(DIV) + 1;
  localparam int FW      = $clog2(FILTER_LEN) + 1;

  localparam logic [PW-1:0] PLAST = PW'(DIV - 1);
  localparam logic [FW-1:0] FLAST = FW'(FILTER_LEN - 1);

  if (SYNC_STAGES < 2) begin : g_chk_sync
    $error("SYNC_STAGES must be at least 2");
  end
  if (FILTER_LEN < 1) begin : g_chk_filter
    $error("FILTER_LEN must be at least 1");
  end
  if (STUCK_TICKS < 1) begin : g_chk_stuck
    $error("STUCK_TICKS must be at least 1");
  end

  // Prescaler: clk_en is registered, so it rises on the DIV-th edge after reset.
  logic [PW-1:0] pcnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pcnt   <= '0;
      clk_en <= 1'b0;
    end else begin
      clk_en <= (pcnt == PLAST);
      pcnt   <= (pcnt == PLAST) ? '0 : pcnt + PW'(1);
    end
  end

  // Synchronisers reset to the released (high) level.
  logic [1:0] sync_q [SYNC_STAGES];
  logic [1:0] s;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= 2'b11;
    end else begin
      sync_q[0] <= pad_i;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  assign s = sync_q[SYNC_STAGES-1];

`ifdef I2C_LINE_CONDITIONER_STUCK_EN
  localparam int SW = $clog2(STUCK_TICKS + 1);
  localparam logic [SW-1:0] SMAX  = SW'(STUCK_TICKS);
  localparam logic [SW-1:0] SLAST = SW'(STUCK_TICKS - 1);

  typedef enum logic {
    SIDE_ACTIVE = 1'b0,
    SIDE_STUCK  = 1'b1
  } side_state_t;
`endif

  for (genvar k = 0; k < 2; k++) begin : g_side
    logic          o_q, o_d;
    logic [FW-1:0] fcnt_q, fcnt_d;
    logic          filt_o;
    logic [FW-1:0] filt_cnt;

    // Plain filter result for this tick; the side controller decides whether it applies.
    always_comb begin
      filt_o   = o_q;
      filt_cnt = fcnt_q;
      if (s[k] == o_q) begin
        filt_cnt = '0;
      end else if (fcnt_q == FLAST) begin
        filt_o   = s[k];
        filt_cnt = '0;
      end else begin
        filt_cnt = fcnt_q + FW'(1);
      end
    end

`ifdef I2C_LINE_CONDITIONER_STUCK_EN
    side_state_t   state_q, state_d;
    logic [SW-1:0] scnt_q, scnt_d;

    always_comb begin
      state_d = state_q;
      scnt_d  = scnt_q;
      o_d     = o_q;
      fcnt_d  = fcnt_q;
      if (clk_en) begin
        case (state_q)
          SIDE_ACTIVE: begin
            o_d    = filt_o;
            fcnt_d = filt_cnt;
            if (o_q) begin
              scnt_d = '0;
            end else if (scnt_q == SLAST) begin
              // Held low too long: force the side released and park the filter.
              state_d = SIDE_STUCK;
              scnt_d  = SMAX;
              o_d     = 1'b1;
              fcnt_d  = '0;
            end else begin
              scnt_d = scnt_q + SW'(1);
            end
          end
          SIDE_STUCK: begin
            o_d = 1'b1;
            if (s[k]) begin
              state_d = SIDE_ACTIVE;
              scnt_d  = '0;
              fcnt_d  = '0;
            end
          end
          default: state_d = SIDE_ACTIVE;
        endcase
      end
    end

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        state_q <= SIDE_ACTIVE;
        scnt_q  <= '0;
      end else begin
        state_q <= state_d;
        scnt_q  <= scnt_d;
      end
    end

    assign stuck[k] = (state_q == SIDE_STUCK);
`else
    always_comb begin
      o_d    = o_q;
      fcnt_d = fcnt_q;
      if (clk_en) begin
        o_d    = filt_o;
        fcnt_d = filt_cnt;
      end
    end

    assign stuck[k] = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        o_q    <= 1'b1;
        fcnt_q <= '0;
      end else begin
        o_q    <= o_d;
        fcnt_q <= fcnt_d;
      end
    end

    assign o[k] = o_q;
  end

endmodule

// File: tb/tb_i2c_line_conditioner.sv
// tb/tb_i2c_line_conditioner.sv - self-checking bench for i2c_line_conditioner
// Reference model: tick schedule by edge count, sync as a delay queue, filter as a sample window.
module tb_i2c_line_conditioner;
  localparam int DIV  = 8;
  localparam int SYNC = 2;
  localparam int FLEN = 3;
  localparam int STK  = 10;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [1:0] pad_i = 2'b11;
  logic       clk_en;
  logic [1:0] o;
  logic [1:0] stuck;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  i2c_line_conditioner #(
    .CLK_HZ(24000000), .TICK_HZ(3000000), .SYNC_STAGES(SYNC),
    .FILTER_LEN(FLEN), .STUCK_TICKS(STK)
  ) dut (
    .clk(clk), .reset(reset), .pad_i(pad_i),
    .clk_en(clk_en), .o(o), .stuck(stuck)
  );

  logic [1:0] sq [$];
  bit         hist [2][$];
  int         n;
  bit         exp_en;
  bit   [1:0] exp_o;
  bit   [1:0] exp_st;
`ifdef I2C_LINE_CONDITIONER_STUCK_EN
  int         low_ticks [2];
`endif

  task automatic model_reset();
    sq.delete();
    repeat (SYNC) sq.push_back(2'b11);
    hist[0].delete();
    hist[1].delete();
    n = 0; exp_en = 0; exp_o = 2'b11; exp_st = 2'b00;
`ifdef I2C_LINE_CONDITIONER_STUCK_EN
    low_ticks[0] = 0; low_ticks[1] = 0;
`endif
  endtask

  // A side flips once its last FLEN tick samples all disagree with it.
  function automatic bit all_differ(int k);
    if (hist[k].size() < FLEN) return 0;
    for (int j = 0; j < hist[k].size(); j++)
      if (hist[k][j] == exp_o[k]) return 0;
    return 1;
  endfunction

  task automatic model_tick(input logic [1:0] s);
    for (int k = 0; k < 2; k++) begin
`ifdef I2C_LINE_CONDITIONER_STUCK_EN
      if (exp_st[k]) begin
        if (s[k]) begin exp_st[k] = 0; low_ticks[k] = 0; hist[k].delete(); end
        continue;
      end
      if (!exp_o[k]) begin
        low_ticks[k]++;
        if (low_ticks[k] == STK) begin
          exp_st[k] = 1; exp_o[k] = 1; hist[k].delete();
          continue;
        end
      end else begin
        low_ticks[k] = 0;
      end
`endif
      hist[k].push_back(s[k]);
      if (hist[k].size() > FLEN) void'(hist[k].pop_front());
      if (all_differ(k)) exp_o[k] = ~exp_o[k];
    end
  endtask

  task automatic step();
    logic [1:0] s;
    @(posedge clk);
    s = sq.pop_front();
    sq.push_back(pad_i);
    if (exp_en) model_tick(s);
    n++;
    exp_en = (n % DIV == 0);
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b1; pad_i = 2'b11;
    repeat (3) @(negedge clk);
    checks++;
    if ({clk_en, o, stuck} !== 5'b0_11_00) begin
      errors++;
      $display("FAIL reset_hold got en=%b o=%b stuck=%b want en=0 o=11 stuck=00", clk_en, o, stuck);
    end
    reset = 1'b0;
    model_reset();
    for (int i = 1; i <= 3 * DIV; i++) begin
      step();
      checks++;
      if ({clk_en, o, stuck} !== {(i % DIV == 0), 2'b11, 2'b00}) begin
        errors++;
        $display("FAIL reset_ticks cyc %0d got en=%b o=%b stuck=%b want en=%b o=11 stuck=00",
                 i, clk_en, o, stuck, (i % DIV == 0));
      end
    end
  endtask

  task automatic test_short_glitch();
    for (int i = 0; i < DIV; i++) begin
      if (n % DIV == 0) break;
      step();
    end
    for (int i = 0; i < 48; i++) begin
      pad_i = (i < 2 * DIV) ? 2'b10 : 2'b11;
      step();
      checks++;
      if ({clk_en, o, stuck} !== {exp_en, exp_o, exp_st} || o !== 2'b11) begin
        errors++;
        $display("FAIL short_glitch cyc %0d got en=%b o=%b stuck=%b want en=%b o=%b stuck=%b",
                 i, clk_en, o, stuck, exp_en, exp_o, exp_st);
      end
    end
  endtask

  task automatic test_hold_low();
    for (int i = 0; i < 80; i++) begin
      pad_i = (i < 40) ? 2'b10 : 2'b11;
      step();
      checks++;
      if ({clk_en, o, stuck} !== {exp_en, exp_o, exp_st} || o[1] !== 1'b1) begin
        errors++;
        $display("FAIL hold_low cyc %0d got en=%b o=%b stuck=%b want en=%b o=%b stuck=%b",
                 i, clk_en, o, stuck, exp_en, exp_o, exp_st);
      end
      if (i == 39) begin
        checks++;
        if (o !== 2'b10) begin
          errors++;
          $display("FAIL hold_low_fell got o=%b want o=10", o);
        end
      end
    end
    checks++;
    if (o !== 2'b11) begin
      errors++;
      $display("FAIL hold_low_rose got o=%b want o=11", o);
    end
  endtask

  task automatic test_both_sides();
    for (int i = 0; i < 28; i++) begin
      pad_i = 2'b00;
      step();
      checks++;
      if ({clk_en, o, stuck} !== {exp_en, exp_o, exp_st} || o[0] !== o[1]) begin
        errors++;
        $display("FAIL both_fall cyc %0d got en=%b o=%b stuck=%b want en=%b o=%b stuck=%b",
                 i, clk_en, o, stuck, exp_en, exp_o, exp_st);
      end
    end
    checks++;
    if (o !== 2'b00) begin
      errors++;
      $display("FAIL both_low got o=%b want o=00", o);
    end
    for (int i = 0; i < 4 * DIV; i++) begin
      pad_i = {((i / DIV) % 2 == 0), 1'b0};
      step();
      checks++;
      if ({clk_en, o, stuck} !== {exp_en, exp_o, exp_st} || o[1] !== 1'b0) begin
        errors++;
        $display("FAIL toggle_side1 cyc %0d got en=%b o=%b stuck=%b want en=%b o=%b stuck=%b (o[1]=0)",
                 i, clk_en, o, stuck, exp_en, exp_o, exp_st);
      end
    end
    for (int i = 0; i < 40; i++) begin
      pad_i = 2'b11;
      step();
      checks++;
      if ({clk_en, o, stuck} !== {exp_en, exp_o, exp_st}) begin
        errors++;
        $display("FAIL both_recover cyc %0d got en=%b o=%b stuck=%b want en=%b o=%b stuck=%b",
                 i, clk_en, o, stuck, exp_en, exp_o, exp_st);
      end
    end
  endtask

  task automatic test_stuck();
    logic [1:0] want_o, want_st;
`ifdef I2C_LINE_CONDITIONER_STUCK_EN
    want_o = 2'b11; want_st = 2'b10;
`else
    want_o = 2'b01; want_st = 2'b00;
`endif
    for (int i = 0; i < 160 + 4 * DIV; i++) begin
      pad_i = (i < 160) ? 2'b01 : 2'b11;
      step();
      checks++;
      if ({clk_en, o, stuck} !== {exp_en, exp_o, exp_st}) begin
        errors++;
        $display("FAIL stuck_run cyc %0d got en=%b o=%b stuck=%b want en=%b o=%b stuck=%b",
                 i, clk_en, o, stuck, exp_en, exp_o, exp_st);
      end
      if (i == 159) begin
        checks++;
        if (o !== want_o || stuck !== want_st) begin
          errors++;
          $display("FAIL stuck_held got o=%b stuck=%b want o=%b stuck=%b", o, stuck, want_o, want_st);
        end
      end
    end
    checks++;
    if (stuck !== 2'b00 || o !== 2'b11) begin
      errors++;
      $display("FAIL stuck_cleared got o=%b stuck=%b want o=11 stuck=00", o, stuck);
    end
  endtask

  task automatic test_random();
    int len;
    for (int r = 0; r < 200; r++) begin
      pad_i = 2'($urandom_range(0, 3));
      len = $urandom_range(1, 40);
      for (int i = 0; i < len; i++) begin
        step();
        checks++;
        if ({clk_en, o, stuck} !== {exp_en, exp_o, exp_st}) begin
          errors++;
          $display("FAIL random run %0d cyc %0d pad=%b got en=%b o=%b stuck=%b want en=%b o=%b stuck=%b",
                   r, i, pad_i, clk_en, o, stuck, exp_en, exp_o, exp_st);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    pad_i = 2'b11;
    repeat (40) step();
    pad_i = 2'b01;
    repeat (40) step();
    checks++;
    if (o !== 2'b01) begin
      errors++;
      $display("FAIL mid_setup got o=%b want o=01", o);
    end
    pad_i = 2'b00;
    for (int i = 0; i < 40; i++) begin
      step();
      if (hist[0].size() >= 2 && hist[0][hist[0].size()-1] == 0 && hist[0][hist[0].size()-2] == 0) break;
    end
    #2 reset = 1'b1;
    #1;
    checks++;
    if ({clk_en, o, stuck} !== 5'b0_11_00) begin
      errors++;
      $display("FAIL mid_reset_async got en=%b o=%b stuck=%b want en=0 o=11 stuck=00", clk_en, o, stuck);
    end
    pad_i = 2'b11;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    for (int i = 1; i <= 2 * DIV; i++) begin
      step();
      checks++;
      if ({clk_en, o, stuck} !== {exp_en, exp_o, exp_st} || clk_en !== (i % DIV == 0)) begin
        errors++;
        $display("FAIL mid_restart cyc %0d got en=%b o=%b stuck=%b want en=%b o=%b stuck=%b",
                 i, clk_en, o, stuck, (i % DIV == 0), exp_o, exp_st);
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_short_glitch();
    test_hold_low();
    test_both_sides();
    test_stuck();
    test_random();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
